// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared mt* operation codes, FSM states and helpers for the multiply/divide unit
package mul_div_pkg;
  localparam logic [2:0] mtDisabled         = 3'd0;
  localparam logic [2:0] mtMultiply         = 3'd1;
  localparam logic [2:0] mtMultiplyUnsigned = 3'd2;
  localparam logic [2:0] mtDivide           = 3'd3;
  localparam logic [2:0] mtDivideUnsigned   = 3'd4;
  localparam logic [2:0] mtSetHi            = 3'd5;
  localparam logic [2:0] mtSetLo            = 3'd6;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;
  function automatic logic is_mul(input logic [2:0] op);
    return op == mtMultiply || op == mtMultiplyUnsigned;
  endfunction
  function automatic logic is_long(input logic [2:0] op);
    return is_mul(op) || op == mtDivide || op == mtDivideUnsigned;
  endfunction
endpackage

// File: rtl/mul_div_datapath.sv
// mul_div_datapath: combinational {hi,lo} result for mult/multu/div/divu incl. div-by-zero and overflow
module mul_div_datapath
  import mul_div_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output hilo_t       res
);
  logic signed [63:0] sprod;
  logic [63:0] uprod;
  logic signed [31:0] sq, sr;
  logic [31:0] uq, ur;
  logic dz, ovf;
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'b0, a} * {32'b0, b};
  assign sq = $signed(a) / $signed(b);
  assign sr = $signed(a) % $signed(b);
  assign uq = a / b;
  assign ur = a % b;
  assign dz = b == 32'd0;
  assign ovf = a == 32'h8000_0000 && b == 32'hffff_ffff;
  // zero divisor and the single signed overflow case bypass the dividers entirely
  assign res = hilo_t'(op == mtMultiply         ? sprod :
                       op == mtMultiplyUnsigned ? uprod :
                       dz                       ? {a, 32'hffff_ffff} :
                       op == mtDivideUnsigned   ? {ur, uq} :
                       ovf                      ? {32'h0, 32'h8000_0000} :
                                                  {sr, sq});
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit owning the architectural HI/LO registers
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mulCtrl,
  input  logic        mulEnable,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        mulOutputSel,
  output logic [31:0] result,
  output logic        busy,
  output logic        busyNext
);
  logic [0:0] state;
  logic [3:0] cnt;
  logic [31:0] hi, lo, hi_pend, lo_pend;
  hilo_t dp;
  mul_div_datapath u_dp (.op(mulCtrl), .a(operandA), .b(operandB), .res(dp));
  assign busy = state == RUN;
  assign busyNext = busy | (mulEnable & is_long(mulCtrl));
  assign result = mulOutputSel ? hi : lo;
  // requests arriving while RUN are ignored; the hazard unit is expected to stall them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      hi <= 32'd0;
      lo <= 32'd0;
      hi_pend <= 32'd0;
      lo_pend <= 32'd0;
    end else if (state == IDLE) begin
      if (mulEnable && is_long(mulCtrl)) begin
        hi_pend <= dp.hi;
        lo_pend <= dp.lo;
        cnt <= is_mul(mulCtrl) ? 4'(MUL_CYCLES - 1) : 4'(DIV_CYCLES - 1);
        state <= RUN;
      end else if (mulEnable && mulCtrl == mtSetHi) hi <= operandA;
      else if (mulEnable && mulCtrl == mtSetLo) lo <= operandA;
    end else if (cnt == 4'd0) begin
      hi <= hi_pend;
      lo <= lo_pend;
      state <= IDLE;
    end else cnt <= cnt - 4'd1;
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven, hand-sequenced and randomized checks of mul_div_unit vs a longint model
module tb_mul_div_unit;
  localparam int MUL_L = 5;
  localparam int DIV_L = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] mulCtrl = 3'd0;
  logic mulEnable = 1'b0;
  logic [31:0] operandA = 32'd0, operandB = 32'd0;
  logic mulOutputSel = 1'b0;
  logic [31:0] result;
  logic busy, busyNext;
  int checks = 0, errors = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  mul_div_unit #(.MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
    .clk(clk), .reset(reset), .mulCtrl(mulCtrl), .mulEnable(mulEnable),
    .operandA(operandA), .operandB(operandB), .mulOutputSel(mulOutputSel),
    .result(result), .busy(busy), .busyNext(busyNext)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    mulOutputSel = 1'b1;
    #1 chk({name, " hi"}, result, eh);
    mulOutputSel = 1'b0;
    #1 chk({name, " lo"}, result, el);
  endtask

  // Reference model: plain 64-bit arithmetic from the architectural rules
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] ch, input logic [31:0] cl);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3, 3'd4: begin
        if (b == 0) return {a, 32'hffff_ffff};
        if (op == 3'd4) return {32'(ua % ub), 32'(ua / ub)};
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      3'd5: return {a, cl};
      3'd6: return {ch, a};
      default: return {ch, cl};
    endcase
  endfunction

  // Issue one op from posedge+1, walk its full latency and compare the committed HI/LO
  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int lat;
    lat = (op == 3'd1 || op == 3'd2) ? MUL_L : (op == 3'd3 || op == 3'd4) ? DIV_L : 0;
    mulCtrl = op;
    operandA = a;
    operandB = b;
    mulEnable = 1'b1;
    #1 chk({name, " busyNext"}, 32'(busyNext), 32'(lat != 0));
    tick();
    mulEnable = 1'b0;
    operandA = $urandom;
    operandB = $urandom;
    for (int i = 0; i < lat; i++) begin
      chk({name, " busy"}, 32'(busy), 32'd1);
      if (i == lat - 1) chk_hilo({name, " pre-commit"}, m_hi, m_lo);
      tick();
    end
    chk({name, " idle"}, 32'(busy), 32'd0);
    chk_hilo(name, eh, el);
    m_hi = eh;
    m_lo = el;
  endtask

  vec_t vecs[8];
  logic [63:0] e;

  initial begin
    vecs[0] = '{3'd1, 32'hffff_ffff, 32'd2, 32'hffff_ffff, 32'hffff_fffe};
    vecs[1] = '{3'd2, 32'hffff_ffff, 32'd2, 32'h0000_0001, 32'hffff_fffe};
    vecs[2] = '{3'd3, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd};
    vecs[3] = '{3'd3, 32'h8000_0000, 32'hffff_ffff, 32'h0, 32'h8000_0000};
    vecs[4] = '{3'd4, 32'd7, 32'd0, 32'd7, 32'hffff_ffff};
    vecs[5] = '{3'd3, 32'hffff_fff9, 32'd0, 32'hffff_fff9, 32'hffff_ffff};
    vecs[6] = '{3'd4, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[7] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk_hilo("reset", 32'd0, 32'd0);
    reset = 1'b1;
    tick();
    chk("idle busy", 32'(busy), 32'd0);
    chk_hilo("idle", 32'd0, 32'd0);

    foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // mthi then mtlo on consecutive cycles
    mulCtrl = 3'd5; operandA = 32'h1234_5678; mulEnable = 1'b1;
    #1 chk("mthi busyNext", 32'(busyNext), 32'd0);
    tick();
    chk("mthi busy", 32'(busy), 32'd0);
    mulOutputSel = 1'b1;
    #1 chk("mthi hi", result, 32'h1234_5678);
    mulCtrl = 3'd6; operandA = 32'hcafe_babe;
    tick();
    mulEnable = 1'b0;
    chk("mtlo busy", 32'(busy), 32'd0);
    chk_hilo("mthi/mtlo", 32'h1234_5678, 32'hcafe_babe);
    m_hi = 32'h1234_5678;
    m_lo = 32'hcafe_babe;

    // hold and ignore: operand changes and an mtlo request during a mult
    mulCtrl = 3'd1; operandA = 32'd3; operandB = 32'hffff_fffb; mulEnable = 1'b1;
    #1 chk("hold busyNext", 32'(busyNext), 32'd1);
    tick();
    mulCtrl = 3'd6; operandA = 32'hdead_beef; operandB = 32'd9;
    for (int i = 0; i < 2; i++) begin
      chk("hold ignore busy", 32'(busy), 32'd1);
      tick();
    end
    mulEnable = 1'b0;
    for (int i = 2; i < MUL_L; i++) tick();
    chk("hold idle", 32'(busy), 32'd0);
    chk_hilo("hold", 32'hffff_ffff, 32'hffff_fff1);
    m_hi = 32'hffff_ffff;
    m_lo = 32'hffff_fff1;

    // reset two cycles after a div issue
    mulCtrl = 3'd3; operandA = 32'd50; operandB = 32'd3; mulEnable = 1'b1;
    tick();
    mulEnable = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1 chk("midreset busy", 32'(busy), 32'd0);
    chk_hilo("midreset", 32'd0, 32'd0);
    #2 reset = 1'b1;
    tick();
    m_hi = 32'd0;
    m_lo = 32'd0;
    do_op("post-reset mult", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

    for (int n = 0; n < 30; n++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(1, 6));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
      if (n == 5) begin op = 3'd3; a = 32'h8000_0000; b = 32'hffff_ffff; end
      e = model(op, a, b, m_hi, m_lo);
      do_op($sformatf("rand%0d op%0d", n, op), op, a, b, e[63:32], e[31:0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
